// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer streams plus FIFO write-side handshake
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_almostfull;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;

    modport slave (
        input  req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        output req_ready, fifo_wr_en, fifo_data_in
    );

    modport master (
        output req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
        input  req_ready, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational round-robin picker starting after last grant
module fifo_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any_req
);
    localparam int IW = $clog2(N);

    int j;

    // Scan from the furthest position back to last+1 so the nearest requester wins.
    always_comb begin
        onehot  = '0;
        idx     = '0;
        any_req = |req;
        j       = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last) + k) % N;
            if (req[j]) begin
                onehot = N'(1) << j;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for one FIFO write port
// FIFO_ARB_STATS_EN builds the per-producer saturating grant_cnt counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fifo_wr_arbiter_if.slave          bus,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      arb_err,
    output logic [NUM_REQ*STAT_W-1:0] grant_cnt
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);

    state_e            state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              err_q;
    logic              wr_en_q;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDXW-1:0]    pick_idx;
    logic               pick_any;
    logic               wr;
    logic               burst_last;

    fifo_rr_pick #(.N(NUM_REQ)) u_pick (
        .req     (bus.req_valid),
        .last    (last_q),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    // last_q doubles as the granted index while in BURST.
    assign wr         = (state_q == BURST) && bus.req_valid[last_q] && !bus.fifo_full;
    assign burst_last = (cnt_q == CNTW'(MAX_BURST - 1));

    always_comb begin
        bus.fifo_wr_en   = wr;
        bus.req_ready    = wr ? grant_q : '0;
        bus.fifo_data_in = '0;
        if (state_q == BURST) begin
            bus.fifo_data_in = bus.req_data[int'(last_q)*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any && !bus.fifo_full) begin
                    state_d = BURST;
                    grant_d = pick_onehot;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (wr) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                if (!wr || burst_last || bus.fifo_almostfull) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDXW'(NUM_REQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_q | bus.fifo_overflow | (wr_en_q & ~bus.fifo_wr_ack);
            wr_en_q <= wr;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q == BURST);
    assign arb_err = err_q;

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (wr && grant_q[i] && stat_q[i] != {STAT_W{1'b1}}) begin
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized bench for fifo_wr_arbiter with a cycle-level reference model
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR    = 4;
    localparam int W     = 16;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_WIDTH(W)) bus ();
    logic [NR-1:0]        grant;
    logic                 busy;
    logic                 arb_err;
    logic [NR*STAT_W-1:0] grant_cnt;

    fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .grant     (grant),
        .busy      (busy),
        .arb_err   (arb_err),
        .grant_cnt (grant_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // producer and FIFO environment
    bit          p_en    [NR];
    bit          p_valid [NR];
    logic [15:0] p_data  [NR];
    int          p_seq   [NR];
    int          p_acc   [NR];
    int          p_rate;
    int          drop_prod;
    int          drop_at;
    bit          rand_data;
    int          rd_rate;
    int          fcount;
    bit          ack_next;
    bit          inj_ovf;
    bit          inj_ack_drop;

    // reference model
    bit m_busy;
    int m_g;
    int m_last;
    int m_cnt;
    bit m_err;
    bit m_prev_wr;
    int m_stats [NR];

    int          grant_log [$];
    int          blen_log  [$];
    int          wcyc_log  [$];
    logic [15:0] wdata_log [$];
    int          cyc;
    int          full_viol;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy    = 0;
        m_g       = 0;
        m_last    = NR - 1;
        m_cnt     = 0;
        m_err     = 0;
        m_prev_wr = 0;
        for (int i = 0; i < NR; i++) m_stats[i] = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]         = p_valid[i];
            bus.req_data[i*W +: W]   = p_data[i];
        end
        bus.fifo_full       = (fcount >= DEPTH);
        bus.fifo_almostfull = (fcount == DEPTH - 1);
        bus.fifo_wr_ack     = ack_next;
        bus.fifo_overflow   = inj_ovf;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            p_en[i] = 0; p_valid[i] = 0; p_data[i] = '0; p_seq[i] = 1; p_acc[i] = 0;
        end
        p_rate = 100; drop_prod = -1; drop_at = 0; rand_data = 0; rd_rate = 0;
        fcount = 0; ack_next = 0; inj_ovf = 0; inj_ack_drop = 0;
        drive_inputs();
        model_reset();
        grant_log.delete(); blen_log.delete(); wcyc_log.delete(); wdata_log.delete();
        cyc = 0; full_viol = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic new_valid(input int i);
        p_valid[i] = p_en[i] && ($urandom % 100 < p_rate);
        if (p_valid[i]) begin
            p_data[i] = rand_data ? 16'($urandom) : 16'((i << 12) | (p_seq[i] & 12'hFFF));
            p_seq[i]++;
        end
    endtask

    task automatic one_cycle();
        bit          full, af, e_wr, any, rd;
        logic [NR-1:0] e_ready, e_grant;
        logic [15:0] e_data;
        logic [NR*STAT_W-1:0] e_cnt;
        bit          new_err;
        @(negedge clk);
        drive_inputs();
        #1;
        full    = (fcount >= DEPTH);
        af      = (fcount == DEPTH - 1);
        e_wr    = m_busy && p_valid[m_g] && !full;
        e_ready = e_wr ? NR'(1 << m_g) : '0;
        e_grant = m_busy ? NR'(1 << m_g) : '0;
        e_data  = m_busy ? p_data[m_g] : '0;
        e_cnt   = '0;
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < NR; i++) e_cnt[i*STAT_W +: STAT_W] = STAT_W'(m_stats[i]);
`endif
        chk("wr_en",     64'(bus.fifo_wr_en),   64'(e_wr));
        chk("req_ready", 64'(bus.req_ready),    64'(e_ready));
        chk("data_in",   64'(bus.fifo_data_in), 64'(e_data));
        chk("grant",     64'(grant),            64'(e_grant));
        chk("busy",      64'(busy),             64'(m_busy));
        chk("arb_err",   64'(arb_err),          64'(m_err));
        chk("grant_cnt", 64'(grant_cnt),        64'(e_cnt));
        if (bus.fifo_wr_en && full) full_viol++;
        if (e_wr) begin
            wdata_log.push_back(e_data);
            wcyc_log.push_back(cyc);
            if (m_stats[m_g] < 65535) m_stats[m_g]++;
        end

        new_err = m_err || inj_ovf || (m_prev_wr && !ack_next);
        if (!m_busy) begin
            any = 0;
            for (int i = 0; i < NR; i++) any |= p_valid[i];
            if (any && !full) begin
                for (int k = 1; k <= NR; k++) begin
                    if (!m_busy && p_valid[(m_last + k) % NR]) begin
                        m_busy = 1;
                        m_g    = (m_last + k) % NR;
                        m_last = m_g;
                        m_cnt  = 0;
                        grant_log.push_back(m_g);
                    end
                end
            end
        end else begin
            if (e_wr) m_cnt++;
            if (!e_wr || m_cnt == MB || af) begin
                m_busy = 0;
                blen_log.push_back(m_cnt);
            end
        end
        m_prev_wr = e_wr;
        m_err     = new_err;

        rd     = (fcount > 0) && ($urandom % 100 < rd_rate);
        fcount = fcount + int'(e_wr) - int'(rd);
        ack_next = e_wr && !inj_ack_drop;
        if (inj_ack_drop && e_wr) inj_ack_drop = 0;
        inj_ovf = 0;

        for (int i = 0; i < NR; i++) begin
            if (e_ready[i]) begin
                p_acc[i]++;
                if (i == drop_prod && p_acc[i] == drop_at) p_valid[i] = 0;
                else new_valid(i);
            end else if (!p_valid[i]) begin
                new_valid(i);
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) one_cycle();
    endtask

    initial begin
        // reset state
        do_reset();
        #1;
        chk("rst_grant",  64'(grant), 0);
        chk("rst_busy",   64'(busy), 0);
        chk("rst_wr_en",  64'(bus.fifo_wr_en), 0);
        chk("rst_ready",  64'(bus.req_ready), 0);
        chk("rst_err",    64'(arb_err), 0);
        chk("rst_cnt",    64'(grant_cnt), 0);
        chk("rst_data",   64'(bus.fifo_data_in), 0);

        // single producer into an empty FIFO, no reads
        do_reset();
        p_en[0] = 1;
        run(20);
        chk("single_words", wdata_log.size(), 8);
        for (int i = 0; i < 8 && i < wdata_log.size(); i++)
            chk("single_data", 64'(wdata_log[i]), 64'(i + 1));
        if (wcyc_log.size() == 8) begin
            chk("single_gap_a", wcyc_log[3] - wcyc_log[0], 3);
            chk("single_gap_b", wcyc_log[4] - wcyc_log[3], 2);
            chk("single_gap_c", wcyc_log[7] - wcyc_log[4], 3);
        end
        chk("single_full",   fcount, DEPTH);
        chk("single_bursts", grant_log.size(), 2);
        chk("single_noviol", full_viol, 0);

        // four continuous producers, FIFO drained every cycle
        do_reset();
        for (int i = 0; i < NR; i++) p_en[i] = 1;
        rd_rate = 100;
        run(30);
        if (grant_log.size() >= 5) begin
            chk("rr_0", grant_log[0], 0);
            chk("rr_1", grant_log[1], 1);
            chk("rr_2", grant_log[2], 2);
            chk("rr_3", grant_log[3], 3);
            chk("rr_4", grant_log[4], 0);
            chk("rr_len", blen_log[0] + blen_log[1] + blen_log[2] + blen_log[3], 16);
        end else chk("rr_grants", grant_log.size(), 5);

        // producer 2 drops valid after two words
        do_reset();
        for (int i = 0; i < NR; i++) p_en[i] = 1;
        rd_rate = 100; drop_prod = 2; drop_at = 2;
        run(45);
        if (grant_log.size() >= 7 && blen_log.size() >= 3) begin
            chk("drop_order", {8'(grant_log[0]), 8'(grant_log[1]), 8'(grant_log[2]), 8'(grant_log[3]),
                               8'(grant_log[4]), 8'(grant_log[5]), 8'(grant_log[6])},
                              56'h00_01_02_03_00_01_02);
            chk("drop_len", blen_log[2], 2);
        end else chk("drop_grants", grant_log.size(), 7);

        // FIFO preloaded to 7 entries
        do_reset();
        p_en[1] = 1; fcount = DEPTH - 1;
        run(12);
        chk("pre_writes", wdata_log.size(), 1);
        chk("pre_grants", grant_log.size(), 1);
        chk("pre_err",    64'(arb_err), 0);
        rd_rate = 100;
        run(6);
        chk("pre_resume", grant_log.size() > 1, 1);

        // asynchronous reset in the middle of a producer-3 burst
        do_reset();
        p_en[3] = 1; rd_rate = 100;
        run(3);
        @(negedge clk);
        drive_inputs();
        #1;
        chk("mid_busy_pre", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_grant", 64'(grant), 0);
        chk("mid_busy",  64'(busy), 0);
        chk("mid_wr_en", 64'(bus.fifo_wr_en), 0);
        chk("mid_ready", 64'(bus.req_ready), 0);
        do_reset();
        for (int i = 0; i < NR; i++) p_en[i] = 1;
        rd_rate = 100;
        run(3);
        chk("mid_first", grant_log.size() > 0 ? grant_log[0] : 99, 0);

        // randomized traffic with backpressure
        do_reset();
        for (int i = 0; i < NR; i++) p_en[i] = 1;
        p_rate = 60; rd_rate = 45; rand_data = 1;
        run(3000);
        chk("rand_noviol", full_viol, 0);
`ifndef FIFO_ARB_STATS_EN
        chk("stats_off", 64'(grant_cnt), 0);
`endif

        // protocol errors
        do_reset();
        p_en[0] = 1; rd_rate = 100;
        run(3);
        inj_ovf = 1;
        run(2);
        chk("err_ovf", 64'(arb_err), 1);
        do_reset();
        #1;
        chk("err_clear", 64'(arb_err), 0);
        p_en[0] = 1; rd_rate = 100; inj_ack_drop = 1;
        run(6);
        chk("err_ack", 64'(arb_err), 1);

`ifdef FIFO_ARB_STATS_EN
        do_reset();
        p_en[0] = 1; rd_rate = 100;
        run(82000);
        chk("stats_sat",  64'(grant_cnt[15:0]), 64'hFFFF);
        chk("stats_rest", 64'(grant_cnt[NR*STAT_W-1:16]), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
